// File: rtl/ia_arith_pkg.sv
// Shared definitions for the IA arithmetic blocks (multiplier and divider).
//
// Contents:
//   div_state_t - control states of the sequential divider
//   MULT_W      - multiplier operand width, also the divisor/remainder width
//   PROD_W      - multiplier product width, also the dividend/quotient width
//   DIV0_FILL   - fill bit for the quotient reported on a divide by zero
package ia_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  localparam int MULT_W = 16;
  localparam int PROD_W = 32;

  // A divide by zero reports a quotient of all ones, at whatever width the
  // quotient happens to be.
  localparam logic DIV0_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//
// Ports:
//   rem_in  [WD-1:0] - partial remainder, always smaller than the divisor
//   bit_in           - next dividend bit, MSB first
//   divisor [WD-1:0] - divisor, non-zero
//   rem_out [WD-1:0] - partial remainder after this step
//   q_bit            - quotient bit produced by this step
module div_step #(
  parameter int WD = 16
) (
  input  logic [WD-1:0] rem_in,
  input  logic          bit_in,
  input  logic [WD-1:0] divisor,
  output logic [WD-1:0] rem_out,
  output logic          q_bit
);

  logic [WD:0] trial;
  logic [WD:0] diff;

  // The trial value needs WD+1 bits. Because rem_in < divisor, the trial value
  // is below 2*divisor, so the top bit of the difference is its sign. When the
  // subtraction is rejected, the trial value is below the divisor and fits in
  // WD bits.
  always_comb begin
    trial   = {rem_in, bit_in};
    diff    = trial - {1'b0, divisor};
    q_bit   = ~diff[WD];
    rem_out = q_bit ? diff[WD-1:0] : trial[WD-1:0];
  end

endmodule

// File: rtl/division32_16.sv
// Sequential unsigned divider, restoring radix-2, one quotient bit per clock.
// It recovers a multiplier factor from a product and the other factor.
//
// Ports:
//   clk            - rising-edge clock
//   rst            - synchronous active-high reset, aborts a division
//   start          - request pulse, sampled only in IDLE
//   e1    [WN-1:0] - dividend, captured when start is accepted
//   e2    [WD-1:0] - divisor, captured when start is accepted
//   busy           - a division is in progress (RUN or FIN)
//   done           - one-cycle pulse, results valid
//   q     [WN-1:0] - quotient, held until the next result
//   r     [WD-1:0] - remainder, held until the next result
//   div0           - the captured divisor was zero, held with q and r
//
// WD must not exceed WN, and WN must be at least 2.
module division32_16
  import ia_arith_pkg::*;
#(
  parameter int WN = PROD_W,
  parameter int WD = MULT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WN-1:0] e1,
  input  logic [WD-1:0] e2,
  output logic          busy,
  output logic          done,
  output logic [WN-1:0] q,
  output logic [WD-1:0] r,
  output logic          div0
);

  localparam int CW = $clog2(WN);

  div_state_t    state;
  div_state_t    state_next;
  logic [CW-1:0] count;
  logic [WN-1:0] dividend;
  logic [WN-1:0] quot;
  logic [WD-1:0] divisor;
  // The WD+1-bit partial remainder exists only as the trial value inside
  // div_step. Between steps it is always below the divisor, so WD bits hold it.
  logic [WD-1:0] prem;
  logic [WD-1:0] rem_next;
  logic          q_bit;
  logic          zero_div;

  div_step #(.WD(WD)) u_step (
    .rem_in  (prem),
    .bit_in  (dividend[WN-1]),
    .divisor (divisor),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero divisor skips RUN and reports at once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (e2 == '0) ? FIN : RUN;
      RUN:     if (count == '0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath. Operands are copied at the accepted start so e1/e2 may change
  // afterwards. Visible results change only in FIN or on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      dividend <= '0;
      quot     <= '0;
      divisor  <= '0;
      prem     <= '0;
      zero_div <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      div0     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dividend <= e1;
            divisor  <= e2;
            prem     <= '0;
            quot     <= '0;
            count    <= CW'(WN - 1);
            zero_div <= (e2 == '0);
          end
        end
        RUN: begin
          prem     <= rem_next;
          quot     <= {quot[WN-2:0], q_bit};
          dividend <= dividend << 1;
          if (count != '0) count <= count - 1'b1;
        end
        FIN: begin
          done <= 1'b1;
          if (zero_div) begin
            // The dividend register is untouched on this path, so its low
            // bits are e1[WD-1:0].
            q    <= {WN{DIV0_FILL}};
            r    <= dividend[WD-1:0];
            div0 <= 1'b1;
          end else begin
            q    <= quot;
            r    <= prem;
            div0 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_division32_16.sv
// Directed testbench for division32_16.
// Inputs are driven and outputs sampled on the falling edge. In the latency
// counts, the edge that accepts start is edge k, and n counts the edges after
// it until done is seen high.
module tb_division32_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] e1;
  logic [15:0] e2;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [15:0] r;
  logic        div0;

  int checks = 0;
  int fails  = 0;

  division32_16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .e1    (e1),
    .e2    (e2),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .div0  (div0)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait never completes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present operands with start for one edge, then scramble the operands
  task automatic do_start(input logic [31:0] a, input logic [15:0] b);
    start = 1'b1;
    e1    = a;
    e2    = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e1    = 32'hDEADBEEF;
    e2    = 16'h0BAD;
  endtask

  // Count edges until done is seen, with -1 when the budget runs out
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    e1    = 32'd40000;
    e2    = 16'd200;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    checks++; if (q !== 32'h0) begin fails++; $display("[TB] FAIL reset_q: got %h, expected 00000000", q); end
    checks++; if (r !== 16'h0) begin fails++; $display("[TB] FAIL reset_r: got %h, expected 0000", r); end
    checks++; if (div0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_div0: got %b, expected 0", div0); end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_round_trip();
    int n;
    do_start(32'd40000, 16'd200);
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL rt_busy: got %b, expected 1", busy); end
    wait_done(n);
    checks++; if (n !== 33) begin fails++; $display("[TB] FAIL rt_latency: got %0d, expected 33", n); end
    checks++; if (q !== 32'd200) begin fails++; $display("[TB] FAIL rt_q: got %0d, expected 200", q); end
    checks++; if (r !== 16'd0) begin fails++; $display("[TB] FAIL rt_r: got %0d, expected 0", r); end
    checks++; if (div0 !== 1'b0) begin fails++; $display("[TB] FAIL rt_div0: got %b, expected 0", div0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rt_busy_at_done: got %b, expected 0", busy); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL rt_done_fall: got %b, expected 0", done); end
    checks++; if (q !== 32'd200) begin fails++; $display("[TB] FAIL rt_q_hold: got %0d, expected 200", q); end
  endtask

  task automatic test_max_values();
    int n;
    do_start(32'hFFFFFFFF, 16'hFFFF);
    wait_done(n);
    checks++; if (n !== 33) begin fails++; $display("[TB] FAIL max1_latency: got %0d, expected 33", n); end
    checks++; if (q !== 32'h00010001) begin fails++; $display("[TB] FAIL max1_q: got %h, expected 00010001", q); end
    checks++; if (r !== 16'h0000) begin fails++; $display("[TB] FAIL max1_r: got %h, expected 0000", r); end
    @(negedge clk);
    do_start(32'hFFFFFFFF, 16'h0001);
    wait_done(n);
    checks++; if (q !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL max2_q: got %h, expected ffffffff", q); end
    checks++; if (r !== 16'h0000) begin fails++; $display("[TB] FAIL max2_r: got %h, expected 0000", r); end
    checks++; if (div0 !== 1'b0) begin fails++; $display("[TB] FAIL max2_div0: got %b, expected 0", div0); end
  endtask

  task automatic test_remainder();
    int n;
    @(negedge clk);
    do_start(32'd1000003, 16'd1000);
    wait_done(n);
    checks++; if (q !== 32'd1000) begin fails++; $display("[TB] FAIL rem1_q: got %0d, expected 1000", q); end
    checks++; if (r !== 16'd3) begin fails++; $display("[TB] FAIL rem1_r: got %0d, expected 3", r); end
    @(negedge clk);
    do_start(32'd5, 16'd7);
    wait_done(n);
    checks++; if (q !== 32'd0) begin fails++; $display("[TB] FAIL rem2_q: got %0d, expected 0", q); end
    checks++; if (r !== 16'd5) begin fails++; $display("[TB] FAIL rem2_r: got %0d, expected 5", r); end
  endtask

  task automatic test_div0();
    int n;
    @(negedge clk);
    do_start(32'h12345678, 16'h0000);
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL dz_busy: got %b, expected 1", busy); end
    wait_done(n);
    checks++; if (n !== 1) begin fails++; $display("[TB] FAIL dz_latency: got %0d, expected 1", n); end
    checks++; if (q !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL dz_q: got %h, expected ffffffff", q); end
    checks++; if (r !== 16'h5678) begin fails++; $display("[TB] FAIL dz_r: got %h, expected 5678", r); end
    checks++; if (div0 !== 1'b1) begin fails++; $display("[TB] FAIL dz_div0: got %b, expected 1", div0); end
  endtask

  // Start pulses 10 edges into RUN and on the FIN edge must both be ignored.
  // 123456789 = 1234 * 100046 + 25
  task automatic test_handshake();
    int n;
    int done_cnt;
    @(negedge clk);
    do_start(32'd123456789, 16'd1234);
    n        = -1;
    done_cnt = 0;
    for (int i = 1; i <= 36; i++) begin
      if (i == 10 || i == 33) begin
        start = 1'b1;
        e1    = 32'd7;
        e2    = 16'd3;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (n < 0) n = i;
      end
      if (i == 5) begin
        checks++; if (q !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL hs_q_held: got %h, expected ffffffff", q); end
        checks++; if (div0 !== 1'b1) begin fails++; $display("[TB] FAIL hs_div0_held: got %b, expected 1", div0); end
      end
      if (i == 33 || i == 34) begin
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL hs_busy_after_fin edge %0d: got %b, expected 0", i, busy); end
      end
    end
    checks++; if (n !== 33) begin fails++; $display("[TB] FAIL hs_latency: got %0d, expected 33", n); end
    checks++; if (done_cnt !== 1) begin fails++; $display("[TB] FAIL hs_done_count: got %0d, expected 1", done_cnt); end
    checks++; if (q !== 32'd100046) begin fails++; $display("[TB] FAIL hs_q: got %0d, expected 100046", q); end
    checks++; if (r !== 16'd25) begin fails++; $display("[TB] FAIL hs_r: got %0d, expected 25", r); end
    checks++; if (div0 !== 1'b0) begin fails++; $display("[TB] FAIL hs_div0: got %b, expected 0", div0); end
  endtask

  // A start presented on the edge right after done is accepted
  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    do_start(32'd40000, 16'd200);
    wait_done(n);
    checks++; if (q !== 32'd200) begin fails++; $display("[TB] FAIL b2b_first_q: got %0d, expected 200", q); end
    do_start(32'd1000003, 16'd1000);
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accept: got %b, expected 1", busy); end
    wait_done(n);
    checks++; if (n !== 33) begin fails++; $display("[TB] FAIL b2b_latency: got %0d, expected 33", n); end
    checks++; if (q !== 32'd1000) begin fails++; $display("[TB] FAIL b2b_q: got %0d, expected 1000", q); end
    checks++; if (r !== 16'd3) begin fails++; $display("[TB] FAIL b2b_r: got %0d, expected 3", r); end
  endtask

  task automatic test_reset_mid_op();
    int n;
    int done_cnt;
    @(negedge clk);
    do_start(32'hFFFFFFFF, 16'h0001);
    repeat (14) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy: got %b, expected 0", busy); end
    checks++; if (q !== 32'h0) begin fails++; $display("[TB] FAIL abort_q: got %h, expected 00000000", q); end
    checks++; if (r !== 16'h0) begin fails++; $display("[TB] FAIL abort_r: got %h, expected 0000", r); end
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin fails++; $display("[TB] FAIL abort_no_done: got %0d pulses, expected 0", done_cnt); end
    do_start(32'd40000, 16'd200);
    wait_done(n);
    checks++; if (n !== 33) begin fails++; $display("[TB] FAIL post_abort_latency: got %0d, expected 33", n); end
    checks++; if (q !== 32'd200) begin fails++; $display("[TB] FAIL post_abort_q: got %0d, expected 200", q); end
    checks++; if (r !== 16'd0) begin fails++; $display("[TB] FAIL post_abort_r: got %0d, expected 0", r); end
  endtask

  // Test sequence
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    e1    = '0;
    e2    = '0;
    test_reset();
    test_round_trip();
    test_max_values();
    test_remainder();
    test_div0();
    test_handshake();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
